// File: rtl/alu_opmux_pkg.sv
// Shared types and defaults for the ALU operand multiplexer pipeline.
package alu_opmux_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } buf_state_e;

  localparam int unsigned OPMUX_CONST_IDX_DEF = 1;
  localparam int unsigned OPMUX_CONST_VAL_DEF = 4;
  localparam int          OPMUX_DATA_W_DEF    = 32;
  localparam int          OPMUX_SEL_W_DEF     = 2;

  // Reference layout of one buffered entry at the default widths.
  typedef struct packed {
    logic [OPMUX_DATA_W_DEF-1:0] data;
    logic [OPMUX_SEL_W_DEF-1:0]  sel;
    logic                        err;
  } opmux_entry_t;

  function automatic int entry_w(int dw, int sw);
    return dw + sw + 1;
  endfunction

endpackage

// File: rtl/alu_operand_mux_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready_o decodes registered state only.
module skid_buffer_2
  import alu_opmux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, consume;

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign accept      = in_valid_i && in_ready_o;
  assign consume     = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Data is cleared on reset too so the outputs read zero while held in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_operand_mux_pipe.sv
// N-way ALU operand select with constant slot, registered through a 2-entry skid buffer.
// Optional ALU_OPMUX_PERF_EN adds saturating transfer/stall counters.
module alu_operand_mux_pipe
  import alu_opmux_pkg::*;
#(
  parameter int          DATA_W    = OPMUX_DATA_W_DEF,
  parameter int          NUM_SRC   = 4,
  parameter int unsigned CONST_IDX = OPMUX_CONST_IDX_DEF,
  parameter int unsigned CONST_VAL = OPMUX_CONST_VAL_DEF,
  localparam int         SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      sel_err
`ifdef ALU_OPMUX_PERF_EN
  ,
  output logic [15:0]               perf_xfer_cnt,
  output logic [15:0]               perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              err;
  } entry_t;

  localparam int ENTRY_W = entry_w(DATA_W, SEL_W);

  entry_t sel_entry, out_entry;

  // Constant slot wins over the bus; codes past NUM_SRC (incl. unused upper codes) flag an error.
  function automatic entry_t select_src(logic [SEL_W-1:0] s, logic [NUM_SRC*DATA_W-1:0] bus);
    entry_t e;
    e.data = '0;
    e.sel  = s;
    e.err  = 1'b0;
    if (int'(s) == CONST_IDX) begin
      e.data = DATA_W'(CONST_VAL);
    end else if (int'(s) >= NUM_SRC) begin
      e.err = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (int'(s) == k) e.data = bus[k*DATA_W +: DATA_W];
      end
    end
    return e;
  endfunction

  assign sel_entry = select_src(sel, src_bus);

  skid_buffer_2 #(.W(ENTRY_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (sel_entry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_entry)
  );

  assign out_data = out_entry.data;
  assign out_sel  = out_entry.sel;
  assign sel_err  = out_entry.err;

`ifdef ALU_OPMUX_PERF_EN
  logic [15:0] xfer_q, xfer_d, stall_q, stall_d;

  function automatic logic [15:0] sat_inc16(logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    xfer_d  = xfer_q;
    stall_d = stall_q;
    if (out_valid && out_ready)  xfer_d  = sat_inc16(xfer_q);
    if (out_valid && !out_ready) stall_d = sat_inc16(stall_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end

  assign perf_xfer_cnt  = xfer_q;
  assign perf_stall_cnt = stall_q;
`endif

endmodule
